// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between an external controller and the spi_peripheral target.
// The master modport is the controller side and the slave modport is the target side.
interface spi_peripheral_if;
   logic ncs;
   logic sclk;
   logic copi;
   logic cipo;

   modport master (output ncs, output sclk, output copi, input cipo);
   modport slave  (input ncs, input sclk, input copi, output cipo);
endinterface

// File: rtl/spi_peripheral.sv
// spi_peripheral: mode-0 SPI target that writes 16-bit frames into the PWM
// configuration register file.
//
// Frame layout, sent MSB first:
//   bit 15      R/W, where 1 means write
//   bits 14:8   register address
//   bits 7:0    data
//
// The SPI pins are asynchronous to clk. Each pin passes through a
// SYNC_STAGES-deep synchronizer. ncs and sclk each have one more flop for
// edge detection.
//
// Optional macro SPI_READBACK_EN enables read frames on cipo.
// When it is undefined, cipo is tied to 0 and read frames are dropped.
module spi_peripheral #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_ADDR    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   spi_peripheral_if.slave spi,
   output logic [7:0] reg_en_out,
   output logic [7:0] reg_en_pwm_out,
   output logic [7:0] reg_out_3_0_pwm_chanel,
   output logic [7:0] reg_out_7_4_pwm_chanel,
   output logic [7:0] reg_pwm_gen_1_duty_cycle,
   output logic [7:0] reg_pwm_gen_2_duty_cycle,
   output logic [7:0] reg_pwm_gen_3_duty_cycle,
   output logic [7:0] reg_pwm_gen_4_duty_cycle,
   output logic [3:0] reg_pwm_frequency_divider
);

   localparam logic [6:0] MAX_ADDR_C = 7'(MAX_ADDR);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] ncs_sync_r;
   logic [SYNC_STAGES-1:0] sclk_sync_r;
   logic [SYNC_STAGES-1:0] copi_sync_r;
   logic                   ncs_prev_r;
   logic                   sclk_prev_r;
   logic                   ncs_s;
   logic                   sclk_s;
   logic                   copi_s;
   logic                   ncs_fall_s;
   logic                   ncs_rise_s;
   logic                   sclk_rise_s;
   logic                   write_ok_s;

   state_t      state_r;
   logic [4:0]  cnt_r;
   logic [15:0] shift_r;
   logic        ovf_r;

   logic [7:0]  en_r;
   logic [7:0]  en_pwm_r;
   logic [7:0]  out_3_0_r;
   logic [7:0]  out_7_4_r;
   logic [7:0]  duty1_r;
   logic [7:0]  duty2_r;
   logic [7:0]  duty3_r;
   logic [7:0]  duty4_r;
   logic [3:0]  freq_r;

`ifdef SPI_READBACK_EN
   logic        sclk_fall_s;
   logic [6:0]  rd_addr_s;
   logic [7:0]  rd_data_s;
   logic [7:0]  rd_shift_r;
   logic        rd_hold_r;
   logic        cipo_r;
`endif

   // Synchronize the pins and keep one delayed copy of ncs/sclk for edge detection.
   // The ncs chain resets low. If ncs is already low when reset releases
   // (a frame is in progress), no falling edge is seen, so that frame is
   // ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ncs_sync_r  <= {SYNC_STAGES{1'b0}};
         sclk_sync_r <= {SYNC_STAGES{1'b0}};
         copi_sync_r <= {SYNC_STAGES{1'b0}};
         ncs_prev_r  <= 1'b0;
         sclk_prev_r <= 1'b0;
      end else begin
         ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], spi.ncs};
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi.sclk};
         copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], spi.copi};
         ncs_prev_r  <= ncs_sync_r[SYNC_STAGES-1];
         sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
      end
   end

   assign ncs_s       = ncs_sync_r[SYNC_STAGES-1];
   assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
   assign copi_s      = copi_sync_r[SYNC_STAGES-1];
   assign ncs_fall_s  = ncs_prev_r & ~ncs_s;
   assign ncs_rise_s  = ~ncs_prev_r & ncs_s;
   assign sclk_rise_s = ~sclk_prev_r & sclk_s;

   // A frame commits only if it is a complete, non-overflowed write to a valid address.
   assign write_ok_s = (cnt_r == 5'd16) && !ovf_r && shift_r[15] &&
                       (shift_r[14:8] <= MAX_ADDR_C);

`ifdef SPI_READBACK_EN
   assign sclk_fall_s = sclk_prev_r & ~sclk_s;
   // The address is complete when the 8th bit arrives. That bit is still on copi_s.
   assign rd_addr_s   = {shift_r[5:0], copi_s};

   // Select the register being read. Out-of-range addresses read as zero.
   always_comb begin
      rd_data_s = 8'd0;
      if (rd_addr_s <= MAX_ADDR_C) begin
         case (rd_addr_s)
            7'd0:    rd_data_s = en_r;
            7'd1:    rd_data_s = en_pwm_r;
            7'd2:    rd_data_s = out_3_0_r;
            7'd3:    rd_data_s = out_7_4_r;
            7'd4:    rd_data_s = duty1_r;
            7'd5:    rd_data_s = duty2_r;
            7'd6:    rd_data_s = duty3_r;
            7'd7:    rd_data_s = duty4_r;
            7'd8:    rd_data_s = {4'd0, freq_r};
            default: rd_data_s = 8'd0;
         endcase
      end else begin
         rd_data_s = 8'd0;
      end
   end

   assign spi.cipo = cipo_r;
`else
   assign spi.cipo = 1'b0;
`endif

   // Frame FSM: IDLE waits for ncs to fall, SHIFT collects bits, COMMIT writes one register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 5'd0;
         shift_r   <= 16'd0;
         ovf_r     <= 1'b0;
         en_r      <= 8'd0;
         en_pwm_r  <= 8'd0;
         out_3_0_r <= 8'd0;
         out_7_4_r <= 8'd0;
         duty1_r   <= 8'd0;
         duty2_r   <= 8'd0;
         duty3_r   <= 8'd0;
         duty4_r   <= 8'd0;
         freq_r    <= 4'd0;
`ifdef SPI_READBACK_EN
         rd_shift_r <= 8'd0;
         rd_hold_r  <= 1'b0;
         cipo_r     <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
`ifdef SPI_READBACK_EN
               cipo_r <= 1'b0;
`endif
               if (ncs_fall_s) begin
                  cnt_r   <= 5'd0;
                  shift_r <= 16'd0;
                  ovf_r   <= 1'b0;
`ifdef SPI_READBACK_EN
                  rd_shift_r <= 8'd0;
                  rd_hold_r  <= 1'b0;
`endif
                  state_r <= ST_SHIFT;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               // When ncs rises in the same cycle as an sclk edge, the ncs edge wins.
               if (ncs_rise_s) begin
                  state_r <= ST_COMMIT;
               end else if (sclk_rise_s) begin
                  if (cnt_r == 5'd16) begin
                     ovf_r <= 1'b1;
                  end else begin
                     shift_r <= {shift_r[14:0], copi_s};
                     cnt_r   <= cnt_r + 5'd1;
`ifdef SPI_READBACK_EN
                     // On the 8th bit of a read frame, load the addressed register.
                     // The first falling edge after the load is skipped, so the
                     // MSB is sampled on rising edge 9.
                     if ((cnt_r == 5'd7) && !shift_r[6]) begin
                        cipo_r     <= rd_data_s[7];
                        rd_shift_r <= {rd_data_s[6:0], 1'b0};
                        rd_hold_r  <= 1'b1;
                     end else begin
                        rd_hold_r  <= rd_hold_r;
                     end
`endif
                  end
`ifdef SPI_READBACK_EN
               end else if (sclk_fall_s) begin
                  if (rd_hold_r) begin
                     rd_hold_r <= 1'b0;
                  end else begin
                     cipo_r     <= rd_shift_r[7];
                     rd_shift_r <= {rd_shift_r[6:0], 1'b0};
                  end
`endif
               end else begin
                  state_r <= ST_SHIFT;
               end
            end
            ST_COMMIT: begin
               if (write_ok_s) begin
                  case (shift_r[14:8])
                     7'd0:    en_r      <= shift_r[7:0];
                     7'd1:    en_pwm_r  <= shift_r[7:0];
                     7'd2:    out_3_0_r <= shift_r[7:0];
                     7'd3:    out_7_4_r <= shift_r[7:0];
                     7'd4:    duty1_r   <= shift_r[7:0];
                     7'd5:    duty2_r   <= shift_r[7:0];
                     7'd6:    duty3_r   <= shift_r[7:0];
                     7'd7:    duty4_r   <= shift_r[7:0];
                     7'd8:    freq_r    <= shift_r[3:0];
                     default: en_r      <= en_r;
                  endcase
               end else begin
                  en_r <= en_r;
               end
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign reg_en_out                = en_r;
   assign reg_en_pwm_out            = en_pwm_r;
   assign reg_out_3_0_pwm_chanel    = out_3_0_r;
   assign reg_out_7_4_pwm_chanel    = out_7_4_r;
   assign reg_pwm_gen_1_duty_cycle  = duty1_r;
   assign reg_pwm_gen_2_duty_cycle  = duty2_r;
   assign reg_pwm_gen_3_duty_cycle  = duty3_r;
   assign reg_pwm_gen_4_duty_cycle  = duty4_r;
   assign reg_pwm_frequency_divider = freq_r;

endmodule

// File: tb/tb_spi_peripheral.sv
// Testbench for spi_peripheral. A register-file model is updated once per
// frame from the frame-acceptance rules. A compare process checks every
// DUT output against that model on each falling clk edge.
module tb_spi_peripheral;

   localparam int SYNC = 2;
   localparam int MAXA = 8;
   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst_n;

   logic [7:0] reg_en_out;
   logic [7:0] reg_en_pwm_out;
   logic [7:0] reg_out_3_0_pwm_chanel;
   logic [7:0] reg_out_7_4_pwm_chanel;
   logic [7:0] reg_pwm_gen_1_duty_cycle;
   logic [7:0] reg_pwm_gen_2_duty_cycle;
   logic [7:0] reg_pwm_gen_3_duty_cycle;
   logic [7:0] reg_pwm_gen_4_duty_cycle;
   logic [3:0] reg_pwm_frequency_divider;

   int   checks = 0;
   int   errors = 0;
   bit   check_en = 1'b0;
   logic [7:0]  mr [0:8];
   logic [31:0] rd_word;

   spi_peripheral_if spi_bus ();

   spi_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(MAXA)) dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .spi                       (spi_bus),
      .reg_en_out                (reg_en_out),
      .reg_en_pwm_out            (reg_en_pwm_out),
      .reg_out_3_0_pwm_chanel    (reg_out_3_0_pwm_chanel),
      .reg_out_7_4_pwm_chanel    (reg_out_7_4_pwm_chanel),
      .reg_pwm_gen_1_duty_cycle  (reg_pwm_gen_1_duty_cycle),
      .reg_pwm_gen_2_duty_cycle  (reg_pwm_gen_2_duty_cycle),
      .reg_pwm_gen_3_duty_cycle  (reg_pwm_gen_3_duty_cycle),
      .reg_pwm_gen_4_duty_cycle  (reg_pwm_gen_4_duty_cycle),
      .reg_pwm_frequency_divider (reg_pwm_frequency_divider)
   );

   always #5 clk = ~clk;

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (check_en) begin
         chk8("reg_en_out",     reg_en_out,               mr[0]);
         chk8("reg_en_pwm_out", reg_en_pwm_out,           mr[1]);
         chk8("reg_out_3_0",    reg_out_3_0_pwm_chanel,   mr[2]);
         chk8("reg_out_7_4",    reg_out_7_4_pwm_chanel,   mr[3]);
         chk8("duty1",          reg_pwm_gen_1_duty_cycle, mr[4]);
         chk8("duty2",          reg_pwm_gen_2_duty_cycle, mr[5]);
         chk8("duty3",          reg_pwm_gen_3_duty_cycle, mr[6]);
         chk8("duty4",          reg_pwm_gen_4_duty_cycle, mr[7]);
         chk8("freq_div",       {4'd0, reg_pwm_frequency_divider}, mr[8]);
`ifndef SPI_READBACK_EN
         chk8("cipo_zero",      {7'd0, spi_bus.cipo},     8'd0);
`endif
      end
   end

   // Model rule: only a complete 16-bit write to an address <= MAXA changes a register.
   task automatic model_frame(input logic [31:0] bits, input int n);
      logic [6:0] a;
      a = bits[14:8];
      if (n == 16 && bits[15] && a <= 7'(MAXA)) begin
         if (a == 7'd8) mr[8] = {4'd0, bits[3:0]};
         else           mr[a] = bits[7:0];
      end
   endtask

   task automatic shift_bits(input logic [31:0] bits, input int n, output logic [31:0] rd);
      rd = 32'd0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_bus.copi = bits[i];
         repeat (HALF) @(negedge clk);
         spi_bus.sclk = 1'b1;
         rd = {rd[30:0], spi_bus.cipo};
         repeat (HALF) @(negedge clk);
         spi_bus.sclk = 1'b0;
      end
   endtask

   // Send one frame. After ncs rises, wait the allowed latency and then update the model.
   task automatic send_frame(input logic [31:0] bits, input int n, output logic [31:0] rd);
      @(negedge clk);
      spi_bus.ncs = 1'b0;
      repeat (HALF) @(negedge clk);
      shift_bits(bits, n, rd);
      repeat (HALF) @(negedge clk);
      spi_bus.ncs = 1'b1;
      check_en = 1'b0;
      repeat (SYNC + 2) @(posedge clk);
      #1;
      model_frame(bits, n);
      check_en = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int kind;
      int n;
      logic [31:0] fr;

      for (int i = 0; i < 9; i++) mr[i] = 8'd0;
      rst_n = 1'b0;
      spi_bus.ncs  = 1'b1;
      spi_bus.sclk = 1'b0;
      spi_bus.copi = 1'b0;
      repeat (3) @(negedge clk);
      chk8("reset_en",   reg_en_out, 8'h00);
      chk8("reset_freq", {4'd0, reg_pwm_frequency_divider}, 8'h00);
      chk8("reset_cipo", {7'd0, spi_bus.cipo}, 8'h00);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_en = 1'b1;

      // Directed write to address 0.
      send_frame(32'h80FF, 16, rd_word);
      chk8("lit_en_ff", reg_en_out, 8'hFF);
      chk8("lit_duty1_zero", reg_pwm_gen_1_duty_cycle, 8'h00);

      // Duty cycles 1..4, then the frequency divider, which keeps only data[3:0].
      send_frame(32'h8480, 16, rd_word);
      send_frame(32'h8540, 16, rd_word);
      send_frame(32'h86C0, 16, rd_word);
      send_frame(32'h87FF, 16, rd_word);
      send_frame(32'h88AB, 16, rd_word);
      chk8("lit_duty1", reg_pwm_gen_1_duty_cycle, 8'h80);
      chk8("lit_duty3", reg_pwm_gen_3_duty_cycle, 8'hC0);
      chk8("lit_freq",  {4'd0, reg_pwm_frequency_divider}, 8'h0B);

      // Short frame, long frame and out-of-range address must all be dropped.
      send_frame(32'h8155, 16, rd_word);
      send_frame(32'h40BB, 15, rd_word);
      send_frame(32'h102AA, 17, rd_word);
      send_frame(32'hA012, 16, rd_word);
      chk8("lit_en_pwm_55", reg_en_pwm_out, 8'h55);

      // A read frame never changes registers. Without readback, cipo stays 0.
      send_frame(32'h8277, 16, rd_word);
      send_frame(32'h0233, 16, rd_word);
      chk8("lit_out30_77", reg_out_3_0_pwm_chanel, 8'h77);
`ifndef SPI_READBACK_EN
      chk8("read_cipo_hi", rd_word[15:8], 8'h00);
      chk8("read_cipo_lo", rd_word[7:0],  8'h00);
`endif

      // Apply reset mid-frame, then send the same frame in full.
      send_frame(32'h8399, 16, rd_word);
      @(negedge clk);
      spi_bus.ncs = 1'b0;
      repeat (HALF) @(negedge clk);
      shift_bits(32'h83, 8, rd_word);
      check_en = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 9; i++) mr[i] = 8'd0;
      repeat (3) @(negedge clk);
      chk8("midreset_03", reg_out_7_4_pwm_chanel, 8'h00);
      chk8("midreset_en", reg_en_out, 8'h00);
      rst_n = 1'b1;
      check_en = 1'b1;
      repeat (6) @(negedge clk);
      spi_bus.ncs = 1'b1;
      repeat (10) @(negedge clk);
      chk8("stale_frame_dropped", reg_out_7_4_pwm_chanel, 8'h00);
      send_frame(32'h83AA, 16, rd_word);
      chk8("lit_03_aa", reg_out_7_4_pwm_chanel, 8'hAA);

`ifdef SPI_READBACK_EN
      // Readback: bits sampled on rising edges 9..16 carry the register value.
      send_frame(32'h845A, 16, rd_word);
      send_frame(32'h0400, 16, rd_word);
      chk8("readback_data", rd_word[7:0], 8'h5A);
      chk8("readback_duty1", reg_pwm_gen_1_duty_cycle, 8'h5A);
`endif

      // Random frames: valid writes, bad addresses, reads, short and long frames.
      for (int f = 0; f < 40; f++) begin
         kind = $urandom_range(4, 0);
         fr = $urandom;
         n = 16;
         case (kind)
            0: fr = {16'd0, 1'b1, 7'($urandom_range(MAXA, 0)), fr[7:0]};
            1: fr = {16'd0, 1'b1, 7'($urandom_range(127, MAXA + 1)), fr[7:0]};
            2: fr = {16'd0, 1'b0, fr[14:0]};
            3: n = $urandom_range(15, 1);
            default: n = $urandom_range(20, 17);
         endcase
         send_frame(fr, n, rd_word);
      end

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
